// File: rtl/fsm_run_arb.sv
// Round-robin arbiter that runs a sequence FSM for a latched number of fsm_y pulses per grant.
// Optional watchdog on fsm_y gaps is compiled in with FSM_RUN_ARB_TIMEOUT_EN.
module fsm_run_arb #(
  parameter int LEN_W   = 4,
  parameter int TMO_CYC = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [LEN_W-1:0] len0,
  input  logic [LEN_W-1:0] len1,
  output logic [1:0]       gnt,
  output logic [1:0]       done,
  output logic             busy,
  output logic             fsm_en,
  output logic             fsm_clr,
  input  logic             fsm_y,
  input  logic [1:0]       fsm_state,
  output logic             err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CLR  = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [LEN_W-1:0] tgt_q, tgt_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] cnt_inc;
  logic             ptr_q, ptr_d;
  logic             chk_q, chk_d;
  logic             win;
  logic             gnt_held;
  logic             reclr;
  logic             tmo_hit;

  // ptr_q holds the last served requester, so a tie goes to the other one.
  assign win      = req[1] & (~req[0] | ~ptr_q);
  assign gnt_held = |(req & gnt_q);
  assign cnt_inc  = cnt_q + 1'b1;
  assign reclr    = chk_q & (fsm_state != 2'b00);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    chk_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        gnt_d = 2'b00;
        if (|req) begin
          state_d = S_CLR;
          gnt_d   = win ? 2'b10 : 2'b01;
          tgt_d   = win ? len1 : len0;
          cnt_d   = '0;
        end
      end
      S_CLR: begin
        if (!gnt_held) begin
          state_d = S_IDLE;
          gnt_d   = 2'b00;
          ptr_d   = gnt_q[1];
        end else if (tgt_q == '0) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
          chk_d   = 1'b1;
        end
      end
      S_RUN: begin
        if (!gnt_held) begin
          state_d = S_IDLE;
          gnt_d   = 2'b00;
          ptr_d   = gnt_q[1];
        end else if (reclr) begin
          // Sequence FSM did not come out of clear; clear it again.
          state_d = S_CLR;
          cnt_d   = '0;
        end else if (fsm_y) begin
          cnt_d = cnt_inc;
          if (cnt_inc == tgt_q) state_d = S_DONE;
        end else if (tmo_hit) begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = 2'b00;
        ptr_d   = gnt_q[1];
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      gnt_q   <= 2'b00;
      tgt_q   <= '0;
      cnt_q   <= '0;
      ptr_q   <= 1'b1;
      chk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      chk_q   <= chk_d;
    end
  end

`ifdef FSM_RUN_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TMO_CYC + 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;

  always_comb begin
    wd_d    = wd_q;
    tmo_hit = 1'b0;
    if (state_q != S_RUN || fsm_y) begin
      wd_d = '0;
    end else begin
      wd_d = wd_q + 1'b1;
      if (wd_q == WD_W'(TMO_CYC - 1)) tmo_hit = 1'b1;
    end
    err_d = err_q | (tmo_hit & gnt_held & ~reclr);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  // Watchdog limit has no effect in this build.
  logic unused_tmo;
  assign unused_tmo = (TMO_CYC > 0);
  assign tmo_hit    = 1'b0;
  assign err        = 1'b0;
`endif

  assign gnt     = gnt_q;
  assign done    = (state_q == S_DONE) ? gnt_q : 2'b00;
  assign busy    = (state_q != S_IDLE);
  assign fsm_en  = (state_q == S_RUN);
  assign fsm_clr = (state_q == S_CLR);

endmodule
